ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes the operand and control fields that the ID/EX pipeline register presents.
- Holds the ID/EX register frozen through a stall output while it iterates, then writes its 64-bit result into HI/LO.
- Sits between the ID/EX register outputs and the EX/MEM register; the MFHI/MFLO paths read hi_out/lo_out.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clock  in  1  single clock, rising edge.
- startin  in  1  reset, asynchronous, active-high.
- ex_ctrl_in  in  4  EX control field from ID/EX: 4'b1100 MULT, 4'b1101 MULTU, 4'b1110 DIV, 4'b1111 DIVU; any other value is a non-muldiv op.
- op_a  in  XLEN  read_data_1 from ID/EX (multiplicand / dividend).
- op_b  in  XLEN  read_data_2 from ID/EX (multiplier / divisor).
- stall_out  out  1  freezes PC, IF/ID and ID/EX while high.
- busy_out  out  1  high whenever state is not IDLE.
- done_out  out  1  one-cycle pulse when HI/LO update.
- div_zero_out  out  1  sticky flag, set by a DIV/DIVU with op_b==0; cleared by the next accepted op.
- hi_out  out  XLEN  HI register.
- lo_out  out  XLEN  LO register.

Behaviour:
- Reset (startin high, any time, including mid-operation):
  - state=IDLE; hi_out=0, lo_out=0; counter=0; div_zero_out=0; done_out=0; busy_out=0.
  - The operation in flight is abandoned with no HI/LO write.
- start = (ex_ctrl_in[3:2]==2'b11).
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - With start, latch op_a/op_b, latch the op code, and go to BUSY.
  - Signed ops latch magnitudes plus result sign bits: quotient sign = sa^sb; remainder sign = sa.
  - counter=0.
- BUSY:
  - One iteration per clock for exactly XLEN cycles. Advance when counter==XLEN-1.
  - MULT/MULTU: shift-add on a 2*XLEN accumulator.
  - DIV/DIVU: restoring division, one quotient bit per cycle.
- FIX:
  - Conditional two's-complement negation of the product / quotient / remainder for signed ops.
  - Result is written into HI/LO at the clock edge leaving FIX.
  - MULT/MULTU: HI = upper product bits, LO = lower product bits.
  - DIV/DIVU: LO = quotient, HI = remainder.
- DONE:
  - done_out=1 for this single cycle; next state is IDLE.
  - start is ignored in DONE, because the same instruction is still presented by ID/EX this cycle.
- Latency: op visible in IDLE at cycle 0 → HI/LO valid and done_out high in cycle XLEN+2 (34 for XLEN=32).
- stall_out:
  - Combinational.
  - High when (IDLE and start) or state is BUSY or FIX.
  - Low in DONE, so ID/EX advances at the end of the DONE cycle.
- Divide by zero:
  - No trap. LO = all ones; HI = dividend (signed: original op_a).
  - div_zero_out set; latency unchanged.
- Signed overflow: -2^(XLEN-1) / -1 gives LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm; no special case.
- Non-muldiv ex_ctrl_in values never disturb HI/LO or state.
- op_a/op_b/ex_ctrl_in changing during BUSY are ignored, since operands are latched.

Decomposition:
- Shared package holds:
  - op-code constants MULT/MULTU/DIV/DIVU;
  - state encoding typedef (2-bit);
  - XLEN default.
- One sub-module, muldiv_datapath: accumulator, shift/subtract step and negation logic.
- The FSM, counter and stall logic stay in ex_muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; done_out pulse exactly one cycle; stall_out high cycles 0–33 and low at cycle 34.
- MULT -7 × 3 (0xFFFFFFF9, 0x00000003) → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100 / 7 → LO=14, HI=2.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x00001234, div_zero_out=1; next MULTU 2×3 clears the flag and gives LO=6, HI=0.
- Assert startin during BUSY cycle 10 of a MULT → HI=LO=0, busy_out=0 immediately (asynchronous); the following DIVU 9/3 completes normally with LO=3, HI=0.
- Hold ex_ctrl_in=MULTU through the DONE cycle, then switch to ADD (4'b0010) → no second operation starts; busy_out stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// op-code constants, FSM state encoding and default operand width.
package ex_muldiv_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle of the multiply/divide unit: op/operands in,
// stall/status and HI/LO out. The pipeline side is the master.
interface ex_muldiv_unit_if
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic [3:0]      ex_ctrl_in;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall_out;
    logic            busy_out;
    logic            done_out;
    logic            div_zero_out;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;

    modport master (
        output ex_ctrl_in, op_a, op_b,
        input  stall_out, busy_out, done_out, div_zero_out, hi_out, lo_out
    );

    modport slave (
        input  ex_ctrl_in, op_a, op_b,
        output stall_out, busy_out, done_out, div_zero_out, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider sharing one 2*XLEN
// accumulator, plus the sign fix-up applied to the final result.
module muldiv_datapath
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clock,
    input  logic            startin,
    input  logic            load,
    input  logic            step,
    input  logic            is_div_in,
    input  logic            is_signed_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic            div_zero,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;

    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_neg;

    always_comb begin
        sa    = is_signed_in & a_in[XLEN-1];
        sb    = is_signed_in & b_in[XLEN-1];
        mag_a = sa ? -a_in : a_in;
        mag_b = sb ? -b_in : b_in;
    end

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
    end

    // Divide: accumulator holds {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        trial    = acc[2*XLEN-1:XLEN-1];
        ge       = (trial >= {1'b0, operand});
        diff     = trial[XLEN-1:0] - operand;
        div_next = {(ge ? diff : trial[XLEN-1:0]), acc[XLEN-2:0], ge};
    end

    always_ff @(posedge clock or posedge startin) begin
        if (startin) begin
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (load) begin
            is_div  <= is_div_in;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            operand <= is_div_in ? mag_b : mag_a;
            acc     <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
        end else if (step) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    // A zero divisor yields an all-ones quotient that must not be sign-corrected.
    always_comb begin
        prod_neg = -acc;
        res_hi   = acc[2*XLEN-1:XLEN];
        res_lo   = acc[XLEN-1:0];
        if (is_div) begin
            if (neg_q && !div_zero) res_lo = -acc[XLEN-1:0];
            if (neg_r)              res_hi = -acc[2*XLEN-1:XLEN];
        end else if (neg_q) begin
            res_hi = prod_neg[2*XLEN-1:XLEN];
            res_lo = prod_neg[XLEN-1:0];
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit: sequencing FSM, iteration
// counter, pipeline stall and the architectural HI/LO registers.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             startin,
    ex_muldiv_unit_if.slave  bus
);

    // state | meaning
    // IDLE  | waiting; a muldiv op in ID/EX is latched and started
    // BUSY  | one multiply/divide iteration per clock, XLEN iterations
    // FIX   | sign correction; HI/LO written on the edge leaving this state
    // DONE  | result visible, done pulse, stall released; start ignored

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t          state;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0] hi_q, lo_q;
    logic            busy_q, done_q, div_zero_q;
    logic            start, load, step, div_zero_new;
    logic [XLEN-1:0] res_hi, res_lo;

    assign start        = (bus.ex_ctrl_in[3:2] == 2'b11);
    assign load         = (state == ST_IDLE) && start;
    assign step         = (state == ST_BUSY);
    assign div_zero_new = ((bus.ex_ctrl_in == OP_DIV) || (bus.ex_ctrl_in == OP_DIVU))
                          && (bus.op_b == '0);

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clock        (clock),
        .startin      (startin),
        .load         (load),
        .step         (step),
        .is_div_in    (bus.ex_ctrl_in[1]),
        .is_signed_in (~bus.ex_ctrl_in[0]),
        .a_in         (bus.op_a),
        .b_in         (bus.op_b),
        .div_zero     (div_zero_q),
        .res_hi       (res_hi),
        .res_lo       (res_lo)
    );

    always_ff @(posedge clock or posedge startin) begin
        if (startin) begin
            state      <= ST_IDLE;
            counter    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    counter <= '0;
                    if (start) begin
                        state      <= ST_BUSY;
                        busy_q     <= 1'b1;
                        div_zero_q <= div_zero_new;
                    end
                end
                ST_BUSY: begin
                    if (counter == LAST_ITER) begin
                        state <= ST_FIX;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    counter <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Combinational so the op in ID/EX is frozen in the very cycle it is seen.
    assign bus.stall_out    = load || (state == ST_BUSY) || (state == ST_FIX);
    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
    assign bus.div_zero_out = div_zero_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;

endmodule
